// File: rtl/cmd_link_pkg.sv
// Shared types and constants for the cmd_link serial command interface.
package cmd_link_pkg;

  typedef enum logic [0:0] {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_e;

  localparam int unsigned BAUD_DIV_DEF     = 5208;
  localparam int unsigned TIMEOUT_CLKS_DEF = 1_000_000;
  localparam logic [7:0]  RESP_ACK         = 8'hA5;
  localparam int unsigned CMD_OPC_MSB      = 15;

  // Counter width able to hold values 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_trx.sv
// Bit-level 8N1 UART engines: synchronized receiver and independent transmitter.
module uart_trx
  import cmd_link_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int unsigned CW = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]    r_rx_arm;
  logic          r_rx_busy;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;

  // The preset synchronizer contents are not real line history, so edge
  // detection stays disarmed until the real line value reaches r_rx_prev.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_arm   <= 2'd0;
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 4'd0;
      r_rx_shift <= 8'h00;
      rx_rdy     <= 1'b0;
      rx_data    <= 8'h00;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      rx_rdy    <= 1'b0;
      if (r_rx_arm != 2'd3) r_rx_arm <= r_rx_arm + 2'd1;
      if (!r_rx_busy) begin
        if (r_rx_arm == 2'd3 && r_rx_prev && !r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= '0;
          r_rx_bit  <= 4'd0;
        end
      end else if (r_rx_cnt == ((r_rx_bit == 4'd0) ? HALF : FULL)) begin
        r_rx_cnt <= '0;
        r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_sync) r_rx_busy <= 1'b0;  // glitch, not a real start bit
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_sync) begin
            rx_rdy  <= 1'b1;
            rx_data <= r_rx_shift;
          end
        end else begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + CW'(1);
      end
    end
  end

  logic          r_tx_busy;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [9:0]    r_tx_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 4'd0;
      r_tx_shift <= '1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!r_tx_busy) begin
        if (trmt) begin
          r_tx_busy  <= 1'b1;
          r_tx_cnt   <= '0;
          r_tx_bit   <= 4'd0;
          r_tx_shift <= {1'b1, tx_data, 1'b0};
        end
      end else if (r_tx_cnt == FULL) begin
        r_tx_cnt   <= '0;
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx_bit  <= 4'd0;
          tx_done   <= 1'b1;
        end else begin
          r_tx_bit <= r_tx_bit + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + CW'(1);
      end
    end
  end

  assign tx = r_tx_shift[0];

endmodule

// File: rtl/cmd_link.sv
// Two-byte command assembler and response sender over a UART link.
// Optional high/low byte gap timeout: define CMD_LINK_TIMEOUT_EN.
module cmd_link
  import cmd_link_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = BAUD_DIV_DEF,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  output logic                 TX,
  output logic [CMD_OPC_MSB:0] cmd,
  output logic                 cmd_rdy,
  input  logic                 clr_cmd_rdy,
  input  logic                 send_resp,
  input  logic [7:0]           resp,
  output logic                 resp_sent
);

  logic       w_rx_rdy;
  logic [7:0] w_rx_data;

  uart_trx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_trx (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (RX),
    .tx     (TX),
    .rx_rdy (w_rx_rdy),
    .rx_data(w_rx_data),
    .trmt   (send_resp),
    .tx_data(resp),
    .tx_done(resp_sent)
  );

  asm_state_e           r_state, w_state_nxt;
  logic [CMD_OPC_MSB:0] r_cmd, w_cmd_nxt;
  logic                 r_cmd_rdy, w_rdy_nxt;
  logic                 w_tmo_hit;

`ifdef CMD_LINK_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TIMEOUT_CLKS);
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || r_state != WAIT_LO || w_rx_rdy) r_tmo_cnt <= '0;
    else                                          r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end

  assign w_tmo_hit = (r_state == WAIT_LO) && (r_tmo_cnt == TW'(TIMEOUT_CLKS - 1));
`else
  // Timeout length has no effect when the feature is compiled out.
  logic w_tmo_unused;
  assign w_tmo_unused = (TIMEOUT_CLKS == 0);
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= WAIT_HI;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd     <= w_cmd_nxt;
      r_cmd_rdy <= w_rdy_nxt;
    end
  end

  // Clear is applied first so a completing low byte in the same cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_rdy_nxt   = r_cmd_rdy;
    if (clr_cmd_rdy) w_rdy_nxt = 1'b0;
    unique case (r_state)
      WAIT_HI: begin
        if (w_rx_rdy) begin
          w_cmd_nxt[CMD_OPC_MSB -: 8] = w_rx_data;
          w_rdy_nxt                   = 1'b0;
          w_state_nxt                 = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (w_rx_rdy) begin
          w_cmd_nxt[7:0] = w_rx_data;
          w_rdy_nxt      = 1'b1;
          w_state_nxt    = WAIT_HI;
        end else if (w_tmo_hit) begin
          w_state_nxt = WAIT_HI;
        end
      end
      default: w_state_nxt = WAIT_HI;
    endcase
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;

endmodule

// File: tb/tb_cmd_link.sv
// Self-checking bench for cmd_link: table-driven command pairs plus directed corner cases.
module tb_cmd_link;
  import cmd_link_pkg::*;

  localparam int unsigned BAUD = 16;
  localparam int unsigned TMO  = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_sent;

  int checks   = 0;
  int failures = 0;
  int sent_cnt = 0;

  cmd_link #(
    .BAUD_DIV    (BAUD),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp  (send_resp),
    .resp       (resp),
    .resp_sent  (resp_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resp_sent) sent_cnt <= sent_cnt + 1;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_cmd;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts and ends on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic clr_pulse(input string name);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check(name, cmd_rdy, 1'b0);
  endtask

  // Sends val; optionally fires a second send_resp (0x5A) inject cycles in.
  task automatic tx_frame(input logic [7:0] val, input int inject, input string name);
    int   pulses;
    int   pulse_at;
    int   k;
    logic exp_b;
    pulses   = 0;
    pulse_at = -1;
    resp      = val;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
    for (int c = 1; c <= 11 * int'(BAUD); c++) begin
      @(posedge clk);
      #1 send_resp = 1'b0;
      if (c == inject) begin
        send_resp = 1'b1;
        resp      = 8'h5A;
      end
      if (c % BAUD == BAUD / 2 && c / BAUD < 10) begin
        k = c / BAUD;
        if (k == 0)      exp_b = 1'b0;
        else if (k == 9) exp_b = 1'b1;
        else             exp_b = val[k-1];
        check($sformatf("%s tx bit %0d", name, k), TX, exp_b);
      end
      if (resp_sent) begin
        pulses++;
        if (pulse_at < 0) pulse_at = c;
      end
    end
    check({name, " resp_sent count"}, pulses, 1);
    check({name, " resp_sent clock"}, pulse_at, 10 * BAUD);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int ones;
    int snap;
    vecs[0] = '{hi: 8'h40, lo: 8'h02, exp_cmd: 16'h4002};
    vecs[1] = '{hi: 8'hFF, lo: 8'h00, exp_cmd: 16'hFF00};
    vecs[2] = '{hi: 8'h00, lo: 8'hFF, exp_cmd: 16'h00FF};
    vecs[3] = '{hi: 8'hA5, lo: 8'h5A, exp_cmd: 16'hA55A};

    RX = 1'b1; rst_n = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    repeat (3) @(negedge clk);
    check("reset TX", TX, 1'b1);
    check("reset cmd", cmd, 16'h0000);
    check("reset cmd_rdy", cmd_rdy, 1'b0);
    check("reset resp_sent", resp_sent, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].hi, 1'b1);
      check($sformatf("vec%0d rdy after hi", i), cmd_rdy, 1'b0);
      check($sformatf("vec%0d cmd hi", i), cmd[15:8], vecs[i].hi);
      send_byte(vecs[i].lo, 1'b1);
      check($sformatf("vec%0d cmd", i), cmd, vecs[i].exp_cmd);
      check($sformatf("vec%0d rdy", i), cmd_rdy, 1'b1);
      clr_pulse($sformatf("vec%0d clr", i));
      check($sformatf("vec%0d cmd stable", i), cmd, vecs[i].exp_cmd);
    end

    // clr held high across the completing byte: set wins for one clock
    send_byte(8'h11, 1'b1);
    clr_cmd_rdy = 1'b1;
    ones = 0;
    fork
      send_byte(8'h22, 1'b1);
      repeat (11 * BAUD) begin
        @(posedge clk);
        #1 if (cmd_rdy) ones++;
      end
    join
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("set wins rdy cycles", ones, 1);
    check("set wins cmd", cmd, 16'h1122);

    // Full duplex: ack frame while a command arrives
    fork
      tx_frame(RESP_ACK, -1, "ack");
      begin
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
      end
    join
    check("duplex cmd", cmd, 16'h1234);
    check("duplex rdy", cmd_rdy, 1'b1);
    clr_pulse("duplex clr");

    tx_frame(RESP_ACK, 100, "busy ignore");
    repeat (2 * BAUD) @(negedge clk);
    tx_frame(8'h3C, -1, "resp 3c");

    // Bad stop bit is discarded
    send_byte(8'h2C, 1'b0);
    repeat (2 * BAUD) @(negedge clk);
    check("bad stop cmd", cmd, 16'h1234);
    check("bad stop rdy", cmd_rdy, 1'b0);
    send_byte(8'h2C, 1'b1);
    send_byte(8'h00, 1'b1);
    check("after bad stop cmd", cmd, 16'h2C00);
    check("after bad stop rdy", cmd_rdy, 1'b1);
    clr_pulse("bad stop clr");

    // Gap longer than the timeout between high and low byte
    send_byte(8'h23, 1'b1);
    repeat (TMO + 100) @(negedge clk);
    send_byte(8'h40, 1'b1);
`ifdef CMD_LINK_TIMEOUT_EN
    check("tmo after 40 hi", cmd[15:8], 8'h40);
    check("tmo after 40 rdy", cmd_rdy, 1'b0);
    send_byte(8'h01, 1'b1);
    check("tmo cmd", cmd, 16'h4001);
    check("tmo rdy", cmd_rdy, 1'b1);
`else
    check("no tmo cmd", cmd, 16'h2340);
    check("no tmo rdy", cmd_rdy, 1'b1);
    send_byte(8'h01, 1'b1);
    check("no tmo next hi", cmd[15:8], 8'h01);
    check("no tmo next rdy", cmd_rdy, 1'b0);
    send_byte(8'h00, 1'b1);
    check("no tmo completed", cmd, 16'h0100);
`endif
    clr_pulse("tmo clr");

    // Reset during data bit 3 of a high byte while a response is on the wire
    resp = 8'h00;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (4 * BAUD + BAUD / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midframe reset TX", TX, 1'b1);
        check("midframe reset cmd", cmd, 16'h0000);
        rst_n = 1'b1;
      end
    join
    snap = sent_cnt;
    repeat (8 * BAUD) @(negedge clk);
    check("no partial rdy", cmd_rdy, 1'b0);
    check("no partial cmd", cmd, 16'h0000);
    check("aborted tx no resp_sent", sent_cnt, snap);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    check("post reset cmd", cmd, 16'h2000);
    check("post reset rdy", cmd_rdy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
